// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan driver.
//   - SEG_0..SEG_F : active-low glyph patterns, bit order {a,b,c,d,e,f,g}, MSB = a
//   - SEG_DASH     : glyph for decimal values 10-15 (only segment g lit)
//   - SEG_BLANK    : all segments off
//   - SEG_IDX_A..G : bit position of each segment inside a pattern
package seg7_pkg;

    localparam int SEG_IDX_A = 6;
    localparam int SEG_IDX_B = 5;
    localparam int SEG_IDX_C = 4;
    localparam int SEG_IDX_D = 3;
    localparam int SEG_IDX_E = 2;
    localparam int SEG_IDX_F = 1;
    localparam int SEG_IDX_G = 0;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit value to active-low 7-segment pattern.
//   value    : digit value 0-15
//   hex_mode : 1 = show A-F for 10-15, 0 = show a dash for 10-15
//   seg_n    : {a,b,c,d,e,f,g}, active-low
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    input  logic       hex_mode,
    output logic [6:0] seg_n
);

    // Letters only exist in hex mode; decimal mode turns any non-BCD value
    // into a dash so a corrupted BCD counter is visible rather than misleading.
    always_comb begin
        seg_n = SEG_DASH;
        case (value)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = hex_mode ? SEG_A : SEG_DASH;
            4'hB: seg_n = hex_mode ? SEG_B : SEG_DASH;
            4'hC: seg_n = hex_mode ? SEG_C : SEG_DASH;
            4'hD: seg_n = hex_mode ? SEG_D : SEG_DASH;
            4'hE: seg_n = hex_mode ? SEG_E : SEG_DASH;
            4'hF: seg_n = hex_mode ? SEG_F : SEG_DASH;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an N-digit common-anode
// 7-segment display with leading-zero suppression, decimal points, an
// anti-ghosting blank at the start of every digit slot and double-buffered
// (tear-free) digit loads.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : 0 blanks the display and parks the scan at digit 0
//   hex_mode     : 1 = 0-F glyphs, 0 = decimal with dash for 10-15
//   lzs          : leading-zero suppression enable
//   load         : strobe capturing digits_in / dp_in
//   digits_in    : 4 bits per digit, [3:0] = rightmost digit
//   dp_in        : decimal point per digit, 1 = lit
//   seg_n, dp_n  : active-low segments {a..g} and decimal point
//   an_n         : active-low anodes, at most one low
//   frame_done   : one-cycle pulse after the last digit slot of a frame
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hex_mode,
    input  logic                    lzs,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an_n,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]                presc;
    logic [IW-1:0]                idx;
    logic [N_DIGITS-1:0][3:0]     shadow;
    logic [N_DIGITS-1:0][3:0]     pend;
    logic [N_DIGITS-1:0]          shadow_dp;
    logic [N_DIGITS-1:0]          pend_dp;
    logic                         pend_valid;

    logic                         tick;
    logic                         wrap;
    logic [N_DIGITS-1:0]          lead_zero;
    logic                         zero_run;
    logic                         suppress;
    logic [3:0]                   cur_value;
    logic [6:0]                   dec_seg;
    logic [6:0]                   seg_d;
    logic                         dp_d;
    logic [N_DIGITS-1:0]          an_d;

    // The end of the last digit's slot is the frame boundary; gating with en
    // keeps a parked scan from ever producing a boundary.
    assign tick = en && (presc == PRESC_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Slot prescaler and digit index. Disabling parks both at zero so the
    // scan resumes at digit 0 with a fresh blank interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (!en) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= wrap ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Double buffer. Loads land in the pending copy and are promoted only at
    // the frame boundary so a frame never mixes old and new digits. When no
    // frame is in progress (disabled) or the load coincides with the boundary,
    // it goes straight to the shadow copy and supersedes anything pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            shadow_dp  <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (load && (!en || wrap)) begin
            shadow     <= digits_in;
            shadow_dp  <= dp_in;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend       <= digits_in;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
        end else if (wrap && pend_valid) begin
            shadow     <= pend;
            shadow_dp  <= pend_dp;
            pend_valid <= 1'b0;
        end
    end

    // lead_zero[i] is set when digit i and every more-significant digit are 0.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (shadow[i] == 4'd0);
            lead_zero[i] = zero_run;
        end
    end

    assign cur_value = shadow[idx];
    assign suppress  = lzs && (idx != '0) && lead_zero[idx];

    seg7_decode u_decode (
        .value    (cur_value),
        .hex_mode (hex_mode),
        .seg_n    (dec_seg)
    );

    // Next output values. A suppressed digit keeps its anode and decimal
    // point so separators such as "0.05" still render correctly.
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (en && (presc >= BLANK_END)) begin
            an_d[idx] = 1'b0;
            seg_d     = suppress ? SEG_BLANK : dec_seg;
            dp_d      = ~shadow_dp[idx];
        end
    end

    // Registered pin drivers; reset blanks the display asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= seg_d;
            dp_n       <= dp_d;
            an_n       <= an_d;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver with
// N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2. A cycle-time reference model
// derives the expected display from elapsed scan time.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = N * RD;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           hex_mode = 1'b0;
    logic           lzs = 1'b0;
    logic           load = 1'b0;
    logic [4*N-1:0] digits_in = '0;
    logic [N-1:0]   dp_in = '0;
    logic [6:0]     seg_n;
    logic           dp_n;
    logic [N-1:0]   an_n;
    logic           frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    seg7_scan_driver #(
        .N_DIGITS     (N),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .hex_mode   (hex_mode),
        .lzs        (lzs),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed scan time t (mod one frame) gives slot
    // position and digit directly; the displayed number is kept as a value.
    logic [6:0]     font [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    int             t;
    logic [4*N-1:0] m_val, m_pval;
    logic [N-1:0]   m_dp, m_pdp;
    bit             m_pflag;
    logic [6:0]     e_seg;
    logic           e_dp;
    logic [N-1:0]   e_an;
    logic           e_fd;
    int             m_pos, m_dig, m_v;
    bit             m_bnd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; m_val = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_pflag = 0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fd = 1'b0;
        end else if (!en) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fd = 1'b0;
            t = 0;
            if (load) begin m_val = digits_in; m_dp = dp_in; m_pflag = 0; end
        end else begin
            m_pos = t % RD;
            m_dig = t / RD;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = '1;
            if (m_pos >= BC) begin
                e_an = ~(N'(1) << m_dig);
                m_v  = int'((m_val >> (4 * m_dig)) & 16'hF);
                if (lzs && m_dig > 0 && (m_val >> (4 * m_dig)) == 0) e_seg = 7'h7F;
                else if (!hex_mode && m_v >= 10) e_seg = 7'h7E;
                else e_seg = font[m_v];
                e_dp = ~m_dp[m_dig];
            end
            m_bnd = (t == FRAME - 1);
            e_fd  = m_bnd;
            if (m_bnd) begin
                if (load) begin m_val = digits_in; m_dp = dp_in; m_pflag = 0; end
                else if (m_pflag) begin m_val = m_pval; m_dp = m_pdp; m_pflag = 0; end
            end else if (load) begin
                m_pval = digits_in; m_pdp = dp_in; m_pflag = 1;
            end
            t = (t + 1) % FRAME;
        end
    end

    logic [12:0] obs, expv;
    assign obs  = {seg_n, dp_n, an_n, frame_done};
    assign expv = {e_seg, e_dp, e_an, e_fd};

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (obs !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %h want %h", obs, {7'h7F, 1'b1, 4'hF, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_scan();
        int fd_count = 0;
        en = 1'b1; load = 1'b1; digits_in = 16'h1234; dp_in = '0;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 100; c++) begin
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL scan c=%0d: got %h want %h", c, obs, expv);
            end
            if (c >= 20 && c < 84 && frame_done) fd_count++;
            if (c >= 40 && an_n != 4'hF) begin
                n_cmp++;
                if ((an_n == 4'b1110 && seg_n !== 7'b1001100) || (an_n == 4'b1101 && seg_n !== 7'b0000110) ||
                    (an_n == 4'b1011 && seg_n !== 7'b0010010) || (an_n == 4'b0111 && seg_n !== 7'b1001111)) begin
                    n_fail++;
                    $display("[TB] FAIL scan_glyph c=%0d: an %b seg %b", c, an_n, seg_n);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (fd_count != 2) begin
            n_fail++;
            $display("[TB] FAIL frame_done_count: got %0d want 2", fd_count);
        end
    endtask

    task automatic test_hex();
        hex_mode = 1'b1; load = 1'b1; digits_in = 16'hABCD; dp_in = 4'($urandom);
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 80; c++) begin
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL hex c=%0d: got %h want %h", c, obs, expv);
            end
            if (c >= 40 && ((an_n == 4'b1110 && seg_n !== 7'b1000010) || (an_n == 4'b0111 && seg_n !== 7'b0001000))) begin
                n_fail++;
                $display("[TB] FAIL hex_glyph c=%0d: an %b seg %b", c, an_n, seg_n);
            end
            if (c >= 40 && (an_n == 4'b1110 || an_n == 4'b0111)) n_cmp++;
            @(negedge clk);
        end
        hex_mode = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            n_cmp++;
            if (obs !== expv || (an_n != 4'hF && seg_n !== 7'b1111110)) begin
                n_fail++;
                $display("[TB] FAIL dash c=%0d: got %h want %h", c, obs, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lzs();
        lzs = 1'b1; load = 1'b1; digits_in = 16'h0005; dp_in = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 160; c++) begin
            if (c == 80) begin load = 1'b1; digits_in = 16'h0000; dp_in = '0; end
            if (c == 81) load = 1'b0;
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL lzs c=%0d: got %h want %h", c, obs, expv);
            end
            if (c >= 40 && c < 80 && an_n == 4'b1011) begin
                n_cmp++;
                if (seg_n !== 7'h7F || dp_n !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL lzs_dp: seg %b dp %b want 1111111 0", seg_n, dp_n);
                end
            end
            if (c >= 120 && an_n == 4'b1110) begin
                n_cmp++;
                if (seg_n !== 7'b0000001) begin
                    n_fail++;
                    $display("[TB] FAIL lzs_zero: seg %b want 0000001", seg_n);
                end
            end
            @(negedge clk);
        end
        lzs = 1'b0;
    endtask

    task automatic test_double_buffer();
        int k = 0;
        while (t != 10 && k < 100) begin @(negedge clk); k++; end
        n_cmp++;
        if (k >= 100) begin n_fail++; $display("[TB] FAIL db_align: timeout got t=%0d want 10", t); end
        for (int c = 0; c < 70; c++) begin
            load = (c == 0 || c == 2);
            digits_in = (c == 0) ? 16'h1111 : 16'h2222;
            @(negedge clk);
            n_cmp++;
            if (obs !== expv || seg_n === 7'b1001111) begin
                n_fail++;
                $display("[TB] FAIL db c=%0d: got %h want %h", c, obs, expv);
            end
        end
        load = 1'b0;
        k = 0;
        while (t != FRAME - 1 && k < 100) begin @(negedge clk); k++; end
        n_cmp++;
        if (k >= 100) begin n_fail++; $display("[TB] FAIL db_bnd_align: timeout got t=%0d", t); end
        load = 1'b1; digits_in = 16'h3333;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 12; c++) begin
            n_cmp++;
            if (obs !== expv || (an_n == 4'b1110 && seg_n !== 7'b0000110)) begin
                n_fail++;
                $display("[TB] FAIL db_boundary c=%0d: got %h want %h", c, obs, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enable();
        int k = 0;
        while (t % RD != 4 && k < 100) begin @(negedge clk); k++; end
        n_cmp++;
        if (k >= 100) begin n_fail++; $display("[TB] FAIL en_align: timeout got t=%0d", t); end
        en = 1'b0; load = 1'b1; digits_in = 16'h9999; dp_in = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            load = 1'b0;
            n_cmp++;
            if (obs !== expv || an_n !== 4'hF) begin
                n_fail++;
                $display("[TB] FAIL disabled c=%0d: got %h want %h", c, obs, expv);
            end
        end
        en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expv || (c <= 2 && an_n !== 4'hF) ||
                (c == 3 && (an_n !== 4'b1110 || seg_n !== 7'b0000100))) begin
                n_fail++;
                $display("[TB] FAIL reenable c=%0d: got %h want %h", c, obs, expv);
            end
        end
    endtask

    task automatic test_async_reset();
        int k = 0;
        while (t % RD != 5 && k < 100) begin @(negedge clk); k++; end
        n_cmp++;
        if (k >= 100) begin n_fail++; $display("[TB] FAIL rst_align: timeout got t=%0d", t); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (seg_n !== 7'h7F || an_n !== 4'hF || dp_n !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL async_reset: seg %b an %b want 1111111 1111", seg_n, an_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== expv || (an_n == 4'b1110 && seg_n !== 7'b0000001)) begin
                n_fail++;
                $display("[TB] FAIL after_reset c=%0d: got %h want %h", c, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            load = ($urandom_range(0, 11) == 0);
            for (int d = 0; d < N; d++)
                digits_in[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            dp_in = 4'($urandom);
            if ($urandom_range(0, 40) == 0) hex_mode = ~hex_mode;
            if ($urandom_range(0, 40) == 0) lzs = ~lzs;
            if ($urandom_range(0, 90) == 0) en = ~en;
            if (c > 1400) en = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL random c=%0d: got %h want %h", c, obs, expv);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_hex();
        test_lzs();
        test_double_buffer();
        test_enable();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
